vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_if.sv | 24 ++
 rtl/vga_timing_gen.sv | 77 +++++++
 2 files changed

// File: rtl/vga_timing_if.sv
// vga_timing_if: composer handshake and video outputs of the VGA timing generator
interface vga_timing_if;
  logic       enable;
  logic       interlaced;
  logic [7:0] display_data;
  logic       display_next_pixel;
  logic       display_next_line;
  logic       display_next_frame;
  logic       display_current_field;
  logic       hsync_n;
  logic       vsync_n;
  logic       de;
  logic [7:0] pixel_out;
  modport master (
    input  enable, interlaced, display_data,
    output display_next_pixel, display_next_line, display_next_frame, display_current_field,
    output hsync_n, vsync_n, de, pixel_out
  );
  modport slave (
    output enable, interlaced, display_data,
    input  display_next_pixel, display_next_line, display_next_frame, display_current_field,
    input  hsync_n, vsync_n, de, pixel_out
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters, composer strobes and pipelined sync/de/pixel outputs
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int PIPE_DELAY = 2
) (
  input  logic          clk,
  input  logic          rst,
  vga_timing_if.master  bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int SW = 3 * PIPE_DELAY;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          field_q, field_d;
  logic [SW-1:0] sr_q, sr_d;
  logic          de_q, de_d, hs_n_q, hs_n_d, vs_n_q, vs_n_d;
  logic [7:0]    pix_q, pix_d;
  logic          en, h_last, v_last;
  logic [2:0]    raw, dly;
  // raw/dly pack {active, hsync, vsync}; the shift register moves one triple per clock
  always_comb begin
    en      = bus.enable;
    h_last  = h_q == HW'(H_TOTAL - 1);
    v_last  = v_q == VW'(V_TOTAL - 1);
    h_d     = (!en || h_last) ? '0 : h_q + 1'b1;
    v_d     = !en ? '0 : !h_last ? v_q : v_last ? '0 : v_q + 1'b1;
    field_d = !en ? field_q : !bus.interlaced ? 1'b0 : (h_last && v_last) ? ~field_q : field_q;
    raw[2]  = en && h_q < HW'(H_ACTIVE) && v_q < VW'(V_ACTIVE);
    raw[1]  = en && h_q >= HW'(H_ACTIVE + H_FRONT) && h_q < HW'(H_ACTIVE + H_FRONT + H_SYNC);
    raw[0]  = en && v_q >= VW'(V_ACTIVE + V_FRONT) && v_q < VW'(V_ACTIVE + V_FRONT + V_SYNC);
    sr_d    = SW'({sr_q, raw});
    dly     = sr_q[SW-1 -: 3];
    de_d    = dly[2];
    hs_n_d  = ~dly[1];
    vs_n_d  = ~dly[0];
    pix_d   = dly[2] ? bus.display_data : 8'h00;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q     <= '0;
      v_q     <= '0;
      field_q <= 1'b0;
      sr_q    <= '0;
      de_q    <= 1'b0;
      hs_n_q  <= 1'b1;
      vs_n_q  <= 1'b1;
      pix_q   <= 8'h00;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      field_q <= field_d;
      sr_q    <= sr_d;
      de_q    <= de_d;
      hs_n_q  <= hs_n_d;
      vs_n_q  <= vs_n_d;
      pix_q   <= pix_d;
    end
  end
  assign bus.display_next_pixel    = en;
  assign bus.display_next_line     = en && h_last;
  assign bus.display_next_frame    = en && h_last && v_last;
  assign bus.display_current_field = field_q;
  assign bus.de                    = de_q;
  assign bus.hsync_n               = hs_n_q;
  assign bus.vsync_n               = vs_n_q;
  assign bus.pixel_out             = pix_q;
endmodule
